// File: rtl/speaker_arbiter_pkg.sv
// rtl/speaker_arbiter_pkg.sv - shared types and constants for the speaker arbiter
// Contents: FSM state encoding, bus field widths, default tone amplitude,
//           1 ms tick length for a 100 MHz clock, square-wave level helper.
package speaker_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_e;

    localparam int HP_W     = 18;
    localparam int DUR_W    = 12;
    localparam int SAMPLE_W = 12;

    localparam logic [SAMPLE_W-1:0] AMP_DEFAULT         = 12'h7FF;
    localparam int                  TICKS_PER_MS_100MHZ = 100_000;

    function automatic logic [SAMPLE_W-1:0] level_sample(input logic level,
                                                         input logic [SAMPLE_W-1:0] amp);
        return level ? amp : '0;
    endfunction

endpackage

// File: rtl/speaker_arbiter_if.sv
// rtl/speaker_arbiter_if.sv - request/grant/audio bundle between task logic and arbiter
// Signals: enable, req[NREQ], half_period[NREQ*18], dur_ms[NREQ*12] (task logic -> arbiter)
//          grant[NREQ], done[NREQ], busy, audio_out[12]             (arbiter -> task logic)
// Modports: master = task logic side, slave = arbiter side.
interface speaker_arbiter_if #(
    parameter int NREQ = 4
);
    import speaker_arbiter_pkg::*;

    logic                    enable;
    logic [NREQ-1:0]         req;
    logic [NREQ*HP_W-1:0]    half_period;
    logic [NREQ*DUR_W-1:0]   dur_ms;
    logic [NREQ-1:0]         grant;
    logic [NREQ-1:0]         done;
    logic                    busy;
    logic [SAMPLE_W-1:0]     audio_out;

    modport master (
        output enable, req, half_period, dur_ms,
        input  grant, done, busy, audio_out
    );

    modport slave (
        input  enable, req, half_period, dur_ms,
        output grant, done, busy, audio_out
    );

endinterface

// File: rtl/speaker_arbiter_tone_gen.sv
// rtl/speaker_arbiter_tone_gen.sv - square-wave generator for the granted tone
// Ports: clock, rst_n (async active-low), clr (latch half_period and restart high),
//        run (advance one clock of the tone), half_period[18], amp[12] -> sample[12] (registered).
// sample is 0 whenever run is low, so the path goes silent the cycle after a tone stops.
module speaker_arbiter_tone_gen
    import speaker_arbiter_pkg::*;
(
    input  logic                clock,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                run,
    input  logic [HP_W-1:0]     half_period,
    input  logic [SAMPLE_W-1:0] amp,
    output logic [SAMPLE_W-1:0] sample
);

    logic [HP_W-1:0]     hp_q, hp_d;
    logic [HP_W-1:0]     phase_q, phase_d;
    logic                level_q, level_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;

    always_comb begin
        hp_d     = hp_q;
        phase_d  = phase_q;
        level_d  = level_q;
        sample_d = '0;
        if (clr) begin
            hp_d     = half_period;
            phase_d  = '0;
            level_d  = 1'b1;
            sample_d = (half_period == '0) ? '0 : amp;
        end else if (run && (hp_q != '0)) begin
            // A zero half-period keeps the phase frozen so it can never run away.
            if (phase_q == hp_q - HP_W'(1)) begin
                phase_d = '0;
                level_d = ~level_q;
            end else begin
                phase_d = phase_q + HP_W'(1);
            end
            sample_d = level_sample(level_d, amp);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            hp_q     <= '0;
            phase_q  <= '0;
            level_q  <= 1'b0;
            sample_q <= '0;
        end else begin
            hp_q     <= hp_d;
            phase_q  <= phase_d;
            level_q  <= level_d;
            sample_q <= sample_d;
        end
    end

    assign sample = sample_q;

endmodule

// File: rtl/speaker_arbiter.sv
// rtl/speaker_arbiter.sv - round-robin owner of the single speaker DAC path
// Ports: clock, rst_n (async active-low), bus (speaker_arbiter_if.slave):
//        enable/req/half_period/dur_ms in; grant/done/busy/audio_out out, all registered.
// FSM IDLE -> PLAY (timed or held tone) -> GAP (silent guard) -> IDLE.
module speaker_arbiter
    import speaker_arbiter_pkg::*;
#(
    parameter int                  NREQ         = 4,
    parameter int                  TICKS_PER_MS = TICKS_PER_MS_100MHZ,
    parameter int                  GAP_MS       = 10,
    parameter logic [NREQ-1:0]     HOLD_MASK    = '0,
    parameter logic [SAMPLE_W-1:0] AMP          = AMP_DEFAULT
) (
    input  logic               clock,
    input  logic               rst_n,
    speaker_arbiter_if.slave   bus
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;

    arb_state_e        state_q, state_d;
    logic [IW-1:0]     rr_q, rr_d;       // last winner; also the current owner in PLAY
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic              busy_q, busy_d;
    logic [DUR_W-1:0]  dur_q, dur_d;
    logic [TW-1:0]     tick_q, tick_d;
    logic [DUR_W-1:0]  ms_q, ms_d;

    logic [IW-1:0]     winner;
    logic              found;
    logic              tick_hit;
    logic              end_now;
    logic              tone_clr;
    logic              tone_run;

    // First requester after the previous winner, wrapping modulo NREQ.
    always_comb begin
        winner = rr_q;
        found  = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && bus.req[(int'(rr_q) + k) % NREQ]) begin
                winner = IW'((int'(rr_q) + k) % NREQ);
                found  = 1'b1;
            end
        end
    end

    assign tick_hit = (tick_q == TW'(TICKS_PER_MS - 1));

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        done_d   = '0;
        busy_d   = busy_q;
        dur_d    = dur_q;
        tick_d   = tick_q;
        ms_d     = ms_q;
        tone_clr = 1'b0;
        tone_run = 1'b0;
        end_now  = 1'b0;
        if (!bus.enable) begin
            // Mute aborts silently: no done pulse, round-robin pointer untouched.
            state_d = ST_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
            tick_d  = '0;
            ms_d    = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|bus.req) begin
                        state_d  = ST_PLAY;
                        rr_d     = winner;
                        grant_d  = NREQ'(1) << winner;
                        busy_d   = 1'b1;
                        dur_d    = bus.dur_ms[int'(winner)*DUR_W +: DUR_W];
                        tick_d   = '0;
                        ms_d     = '0;
                        tone_clr = 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (HOLD_MASK[rr_q]) begin
                        end_now = !bus.req[rr_q];
                    end else begin
                        end_now = (dur_q == '0) || (tick_hit && (ms_q + 12'd1 == dur_q));
                    end
                    tick_d = tick_hit ? '0 : tick_q + TW'(1);
                    // Held tones have no length limit, so their ms count is not kept.
                    if (tick_hit && !HOLD_MASK[rr_q]) begin
                        ms_d = ms_q + 12'd1;
                    end
                    if (end_now) begin
                        state_d      = ST_GAP;
                        grant_d      = '0;
                        done_d[rr_q] = 1'b1;
                        tick_d       = '0;
                        ms_d         = '0;
                    end else begin
                        tone_run = 1'b1;
                    end
                end
                ST_GAP: begin
                    tick_d = tick_hit ? '0 : tick_q + TW'(1);
                    if (tick_hit) begin
                        ms_d = ms_q + 12'd1;
                        if (ms_q + 12'd1 == 12'(GAP_MS)) begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            tick_d  = '0;
                            ms_d    = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rr_q    <= IW'(NREQ - 1);
            grant_q <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            dur_q   <= '0;
            tick_q  <= '0;
            ms_q    <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            dur_q   <= dur_d;
            tick_q  <= tick_d;
            ms_q    <= ms_d;
        end
    end

    speaker_arbiter_tone_gen u_tone (
        .clock       (clock),
        .rst_n       (rst_n),
        .clr         (tone_clr),
        .run         (tone_run),
        .half_period (bus.half_period[int'(winner)*HP_W +: HP_W]),
        .amp         (AMP),
        .sample      (bus.audio_out)
    );

    assign bus.grant = grant_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;

endmodule

// File: tb/tb_speaker_arbiter.sv
// tb/tb_speaker_arbiter.sv - self-checking bench for speaker_arbiter
module tb_speaker_arbiter;
    import speaker_arbiter_pkg::*;

    localparam int          N   = 4;
    localparam int          T   = 10;
    localparam int          GAP = 2;
    localparam logic [11:0] A   = 12'h7FF;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    speaker_arbiter_if #(.NREQ(N)) bus_t ();
    speaker_arbiter_if #(.NREQ(N)) bus_h ();

    speaker_arbiter #(.NREQ(N), .TICKS_PER_MS(T), .GAP_MS(GAP), .HOLD_MASK(4'b0000), .AMP(A)) dut_t (
        .clock (clock), .rst_n (rst_n), .bus (bus_t.slave));

    speaker_arbiter #(.NREQ(N), .TICKS_PER_MS(T), .GAP_MS(GAP), .HOLD_MASK(4'b0001), .AMP(A)) dut_h (
        .clock (clock), .rst_n (rst_n), .bus (bus_h.slave));

    int tests = 0;
    int fails = 0;
    int model_ptr;
    int hp_tab [N];
    int dur_tab[N];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected sample k clocks into a tone: high for hp clocks, low for hp clocks, ...
    function automatic logic [11:0] tone_at(input int k, input int hp);
        if (hp == 0) return 12'h000;
        return (((k / hp) % 2) == 0) ? A : 12'h000;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [N-1:0] r);
        for (int k = 1; k <= N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int w, input int hp, input int dur);
        hp_tab[w]  = hp;
        dur_tab[w] = dur;
        bus_t.half_period[w*18 +: 18] = 18'(hp);
        bus_t.dur_ms[w*12 +: 12]      = 12'(dur);
    endtask

    // Called on the first PLAY cycle; walks the tone, the done pulse and the gap,
    // returning on the first IDLE cycle.
    task automatic run_grant(input string tag, input int w, input int hp, input int dur);
        int plen;
        plen = (dur == 0) ? 1 : dur * T;
        for (int k = 0; k < plen; k++) begin
            chk($sformatf("%s grant k=%0d", tag, k), 32'(bus_t.grant), 32'(1 << w));
            chk($sformatf("%s audio k=%0d", tag, k), 32'(bus_t.audio_out), 32'(tone_at(k, hp)));
            chk($sformatf("%s busy k=%0d", tag, k), 32'(bus_t.busy), 32'd1);
            chk($sformatf("%s done k=%0d", tag, k), 32'(bus_t.done), 32'd0);
            step();
        end
        chk({tag, " done pulse"}, 32'(bus_t.done), 32'(1 << w));
        chk({tag, " grant end"}, 32'(bus_t.grant), 32'd0);
        chk({tag, " audio end"}, 32'(bus_t.audio_out), 32'd0);
        chk({tag, " busy end"}, 32'(bus_t.busy), 32'd1);
        for (int g = 1; g < GAP * T; g++) begin
            step();
            chk($sformatf("%s gap busy g=%0d", tag, g), 32'(bus_t.busy), 32'd1);
            chk($sformatf("%s gap grant g=%0d", tag, g), 32'(bus_t.grant), 32'd0);
            chk($sformatf("%s gap audio g=%0d", tag, g), 32'(bus_t.audio_out), 32'd0);
            chk($sformatf("%s gap done g=%0d", tag, g), 32'(bus_t.done), 32'd0);
        end
        step();
        chk({tag, " idle busy"}, 32'(bus_t.busy), 32'd0);
        chk({tag, " idle grant"}, 32'(bus_t.grant), 32'd0);
        model_ptr = w;
    endtask

    initial begin
        int seq [4];
        int w, hp_l, dur_l;
        logic [N-1:0] r;

        bus_t.enable = 1'b1; bus_t.req = '0; bus_t.half_period = '0; bus_t.dur_ms = '0;
        bus_h.enable = 1'b1; bus_h.req = '0; bus_h.half_period = '0; bus_h.dur_ms = '0;
        for (int i = 0; i < N; i++) set_req(i, 0, 0);
        model_ptr = N - 1;

        // Reset values
        step(); step();
        chk("reset grant", 32'(bus_t.grant), 32'd0);
        chk("reset done", 32'(bus_t.done), 32'd0);
        chk("reset busy", 32'(bus_t.busy), 32'd0);
        chk("reset audio", 32'(bus_t.audio_out), 32'd0);
        chk("reset grant h", 32'(bus_h.grant), 32'd0);
        chk("reset audio h", 32'(bus_h.audio_out), 32'd0);
        rst_n = 1'b1;
        step();
        chk("idle no req", 32'(bus_t.grant), 32'd0);

        // Round-robin from reset pointer: 0,1,3,0
        set_req(0, 1, 1); set_req(1, 2, 0); set_req(3, 4, 1);
        bus_t.req = 4'b1011;
        seq[0] = 0; seq[1] = 1; seq[2] = 3; seq[3] = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            run_grant($sformatf("rr%0d", i), seq[i], hp_tab[seq[i]], dur_tab[seq[i]]);
        end
        bus_t.req = '0;
        step();
        chk("rr after grant", 32'(bus_t.grant), 32'd0);

        // Single timed tone; request dropped mid-tone must not shorten it
        set_req(1, 3, 2);
        bus_t.req = 4'b0010;
        step();
        bus_t.req = '0;
        run_grant("single", 1, 3, 2);

        // Edge values
        set_req(2, 2, 0);
        bus_t.req = 4'b0100;
        step();
        bus_t.req = '0;
        run_grant("dur0", 2, 2, 0);
        set_req(3, 0, 1);
        bus_t.req = 4'b1000;
        step();
        bus_t.req = '0;
        run_grant("hp0", 3, 0, 1);

        // Mute mid-PLAY
        set_req(0, 2, 3);
        bus_t.req = 4'b0001;
        step();
        model_ptr = 0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("mute pre grant k=%0d", k), 32'(bus_t.grant), 32'd1);
            chk($sformatf("mute pre audio k=%0d", k), 32'(bus_t.audio_out), 32'(tone_at(k, 2)));
            step();
        end
        bus_t.enable = 1'b0;
        step();
        chk("mute grant", 32'(bus_t.grant), 32'd0);
        chk("mute audio", 32'(bus_t.audio_out), 32'd0);
        chk("mute busy", 32'(bus_t.busy), 32'd0);
        chk("mute done", 32'(bus_t.done), 32'd0);
        step();
        chk("muted no grant", 32'(bus_t.grant), 32'd0);
        chk("muted no done", 32'(bus_t.done), 32'd0);
        set_req(1, 1, 1);
        bus_t.req = 4'b1011;
        bus_t.enable = 1'b1;
        w = rr_pick(model_ptr, bus_t.req);
        step();
        bus_t.req = '0;
        run_grant("unmute", w, hp_tab[w], dur_tab[w]);

        // Hold mode on the second instance: dur_ms ignored, ends on req drop
        bus_h.half_period[17:0] = 18'd4;
        bus_h.dur_ms[11:0]      = 12'd1;
        bus_h.req = 4'b0001;
        step();
        for (int k = 0; k < 37; k++) begin
            chk($sformatf("hold grant k=%0d", k), 32'(bus_h.grant), 32'd1);
            chk($sformatf("hold audio k=%0d", k), 32'(bus_h.audio_out), 32'(tone_at(k, 4)));
            chk($sformatf("hold done k=%0d", k), 32'(bus_h.done), 32'd0);
            step();
        end
        chk("hold grant at drop", 32'(bus_h.grant), 32'd1);
        bus_h.req = '0;
        step();
        chk("hold grant end", 32'(bus_h.grant), 32'd0);
        chk("hold done pulse", 32'(bus_h.done), 32'd1);
        chk("hold audio end", 32'(bus_h.audio_out), 32'd0);
        for (int g = 1; g < GAP * T; g++) begin
            step();
            chk($sformatf("hold gap busy g=%0d", g), 32'(bus_h.busy), 32'd1);
        end
        step();
        chk("hold idle busy", 32'(bus_h.busy), 32'd0);

        // Asynchronous reset mid-PLAY
        set_req(2, 3, 3);
        bus_t.req = 4'b0100;
        step();
        chk("prereset grant", 32'(bus_t.grant), 32'd4);
        step(); step(); step();
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst grant", 32'(bus_t.grant), 32'd0);
        chk("async rst audio", 32'(bus_t.audio_out), 32'd0);
        chk("async rst busy", 32'(bus_t.busy), 32'd0);
        chk("async rst done", 32'(bus_t.done), 32'd0);
        step(); step();
        chk("in rst done", 32'(bus_t.done), 32'd0);
        rst_n = 1'b1;
        model_ptr = N - 1;
        set_req(0, 2, 1); set_req(3, 1, 1);
        bus_t.req = 4'b1001;
        step();
        bus_t.req = '0;
        run_grant("post reset", 0, 2, 1);

        // Randomized: held patterns, inputs scrambled after each grant
        for (int it = 0; it < 6; it++) begin
            r = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) set_req(i, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
            bus_t.req = r;
            for (int g = 0; g < 3; g++) begin
                w     = rr_pick(model_ptr, r);
                hp_l  = hp_tab[w];
                dur_l = dur_tab[w];
                step();
                for (int i = 0; i < N; i++) set_req(i, int'($urandom_range(0, 4)), int'($urandom_range(0, 2)));
                run_grant($sformatf("rand%0d.%0d", it, g), w, hp_l, dur_l);
            end
            bus_t.req = '0;
            step();
            chk($sformatf("rand%0d idle", it), 32'(bus_t.grant), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
